beatmap_writer: RTL and testbench

//  Fills the block-data RAM that block_loader reads, one 48-bit record per block.

---
 rtl/beatmap_writer_if.sv | 30 +++
 rtl/beatmap_writer.sv | 148 ++++++++++++++
 tb/tb_beatmap_writer.sv | 364 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/beatmap_writer_if.sv
// Upload-side and RAM-write-side signals of beatmap_writer, bundled with
// modports for the writer (slave) and its driver/observer (master).
interface beatmap_writer_if #(
    parameter int unsigned ADDR_W = 9
);
    logic              start_in;
    logic              finish_in;
    logic [7:0]        byte_in;
    logic              byte_valid_in;
    logic              byte_ready_out;
    logic [ADDR_W-1:0] ram_addr_out;
    logic [47:0]       ram_din_out;
    logic              ram_we_out;
    logic [ADDR_W-1:0] record_count_out;
    logic              busy_out;
    logic              done_out;
    logic [1:0]        error_out;

    modport slave (
        input  start_in, finish_in, byte_in, byte_valid_in,
        output byte_ready_out, ram_addr_out, ram_din_out, ram_we_out,
        output record_count_out, busy_out, done_out, error_out
    );

    modport master (
        output start_in, finish_in, byte_in, byte_valid_in,
        input  byte_ready_out, ram_addr_out, ram_din_out, ram_we_out,
        input  record_count_out, busy_out, done_out, error_out
    );
endinterface

// File: rtl/beatmap_writer.sv
// Packs a byte stream into validated 48-bit block records and writes them to
// RAM addresses 1..N, then commits the record count at address 0.
module beatmap_writer #(
    parameter int unsigned MAX_BLOCK_SIZE = 256,
    parameter int unsigned ADDR_W         = $clog2(MAX_BLOCK_SIZE) + 1
) (
    input  logic            clk_in,
    input  logic            rst_in,
    beatmap_writer_if.slave bus
);
    localparam int unsigned REC_W   = 48;
    localparam int unsigned ASM_W   = 46;
    localparam int unsigned TIME_W  = 18;
    localparam int unsigned IDX_W   = 3;
    localparam int unsigned DIR_MAX = 4;
    localparam int unsigned LAST_IX = 5;

    typedef enum logic [2:0] {IDLE, RECV, WRITE, COMMIT, DONE, ERROR} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic [IDX_W-1:0]  byte_idx_q, byte_idx_d;
    logic [TIME_W-1:0] last_time_q, last_time_d;
    logic [ASM_W-1:0]  asm_q, asm_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [REC_W-1:0]  din_q, din_d;
    logic              we_q, we_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [1:0]        error_q, error_d;

    logic [TIME_W-1:0] rec_time;
    logic [2:0]        rec_dir;
    logic              byte_fire;

    // The assembly register is only 46 bits wide, so byte0[7:6] falls off the top.
    assign rec_time  = asm_q[21:4];
    assign rec_dir   = asm_q[2:0];
    assign bus.byte_ready_out = (state_q == RECV) && !bus.finish_in;
    assign byte_fire = bus.byte_ready_out && bus.byte_valid_in;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        byte_idx_d  = byte_idx_q;
        last_time_d = last_time_q;
        asm_d       = asm_q;
        addr_d      = addr_q;
        din_d       = din_q;
        we_d        = 1'b0;
        error_d     = error_q;

        unique case (state_q)
            IDLE, DONE, ERROR: begin
                if (bus.start_in) begin
                    count_d     = '0;
                    byte_idx_d  = '0;
                    last_time_d = '0;
                    error_d     = 2'd0;
                    state_d     = RECV;
                end
            end
            RECV: begin
                if (bus.finish_in) begin
                    if (byte_idx_q == '0) begin
                        state_d = COMMIT;
                    end else begin
                        error_d = 2'd3;
                        state_d = ERROR;
                    end
                end else if (byte_fire) begin
                    asm_d = {asm_q[ASM_W-9:0], bus.byte_in};
                    if (byte_idx_q == IDX_W'(LAST_IX)) begin
                        byte_idx_d = '0;
                        state_d    = WRITE;
                    end else begin
                        byte_idx_d = byte_idx_q + IDX_W'(1);
                    end
                end
            end
            WRITE: begin
                if (rec_dir > 3'(DIR_MAX)) begin
                    error_d = 2'd1;
                    state_d = ERROR;
                end else if (rec_time < last_time_q) begin
                    error_d = 2'd2;
                    state_d = ERROR;
                end else if (count_q == ADDR_W'(MAX_BLOCK_SIZE)) begin
                    error_d = 2'd3;
                    state_d = ERROR;
                end else begin
                    we_d        = 1'b1;
                    addr_d      = count_q + ADDR_W'(1);
                    din_d       = {2'b00, asm_q};
                    count_d     = count_q + ADDR_W'(1);
                    last_time_d = rec_time;
                    state_d     = RECV;
                end
            end
            COMMIT: begin
                we_d    = 1'b1;
                addr_d  = '0;
                din_d   = REC_W'(count_q);
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RECV) || (state_d == WRITE) || (state_d == COMMIT);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= IDLE;
            count_q     <= '0;
            byte_idx_q  <= '0;
            last_time_q <= '0;
            asm_q       <= '0;
            addr_q      <= '0;
            din_q       <= '0;
            we_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 2'd0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            byte_idx_q  <= byte_idx_d;
            last_time_q <= last_time_d;
            asm_q       <= asm_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
            we_q        <= we_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign bus.ram_addr_out     = addr_q;
    assign bus.ram_din_out      = din_q;
    assign bus.ram_we_out       = we_q;
    assign bus.record_count_out = count_q;
    assign bus.busy_out         = busy_q;
    assign bus.done_out         = done_q;
    assign bus.error_out        = error_q;
endmodule

// File: tb/tb_beatmap_writer.sv
// Bench for beatmap_writer: two instances (depth 256 and depth 4) see the same
// uploads; a record-level model predicts RAM writes and final status.
module tb_beatmap_writer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    beatmap_writer_if #(.ADDR_W(9)) bus_a ();
    beatmap_writer_if #(.ADDR_W(3)) bus_b ();

    beatmap_writer #(.MAX_BLOCK_SIZE(256), .ADDR_W(9)) dut_a (
        .clk_in(clk), .rst_in(rst), .bus(bus_a));
    beatmap_writer #(.MAX_BLOCK_SIZE(4), .ADDR_W(3)) dut_b (
        .clk_in(clk), .rst_in(rst), .bus(bus_b));

    typedef struct {
        int          addr;
        logic [47:0] din;
    } wr_t;

    typedef struct packed {
        logic        we;
        logic [8:0]  addr;
        logic [47:0] din;
        logic [8:0]  cnt;
        logic        busy;
        logic        done;
        logic [1:0]  err;
        logic        rdy;
    } obs_t;

    int    errors = 0;
    int    checks = 0;
    string cur_test = "reset";

    // Record-level model state, one slot per instance.
    wr_t         exp_a[$];
    wr_t         exp_b[$];
    int          m_cnt[2];
    int          m_last[2];
    int          m_err[2];
    int          m_idx[2];
    bit          m_live[2];
    bit          m_done[2];
    int          m_max[2] = '{256, 4};
    logic [47:0] ram[2][257];

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s/%s: got %0h expected %0h", cur_test, name, act, exp);
        end
    endtask

    function automatic obs_t obs(int k);
        obs_t o;
        if (k == 0) begin
            o = {bus_a.ram_we_out, bus_a.ram_addr_out, bus_a.ram_din_out, bus_a.record_count_out,
                 bus_a.busy_out, bus_a.done_out, bus_a.error_out, bus_a.byte_ready_out};
        end else begin
            o = {bus_b.ram_we_out, 9'(bus_b.ram_addr_out), bus_b.ram_din_out,
                 9'(bus_b.record_count_out), bus_b.busy_out, bus_b.done_out,
                 bus_b.error_out, bus_b.byte_ready_out};
        end
        return o;
    endfunction

    function automatic void push_exp(int k, int addr, logic [47:0] din);
        wr_t w;
        w.addr = addr;
        w.din  = din;
        if (k == 0) exp_a.push_back(w);
        else        exp_b.push_back(w);
    endfunction

    function automatic int qsize(int k);
        return (k == 0) ? exp_a.size() : exp_b.size();
    endfunction

    function automatic wr_t qpop(int k);
        return (k == 0) ? exp_a.pop_front() : exp_b.pop_front();
    endfunction

    function automatic logic [47:0] mk(int x, int y, int t, int c, int d);
        return {2'b00, 12'(x), 12'(y), 18'(t), 1'(c), 3'(d)};
    endfunction

    // Model: a complete record is accepted or rejected by the documented rules.
    function automatic void model_record(int k, logic [47:0] rec);
        int t;
        int d;
        t = int'(rec[21:4]);
        d = int'(rec[2:0]);
        m_idx[k] = 0;
        if (d > 4) begin
            m_err[k] = 1; m_live[k] = 0;
        end else if (t < m_last[k]) begin
            m_err[k] = 2; m_live[k] = 0;
        end else if (m_cnt[k] == m_max[k]) begin
            m_err[k] = 3; m_live[k] = 0;
        end else begin
            push_exp(k, m_cnt[k] + 1, {2'b00, rec[45:0]});
            m_cnt[k]++;
            m_last[k] = t;
        end
    endfunction

    function automatic void model_clear(bit live);
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 0; m_last[k] = 0; m_err[k] = 0;
            m_idx[k] = 0; m_done[k] = 1'b0; m_live[k] = live;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_byte(int k, logic [7:0] b, logic v);
        if (k == 0) begin bus_a.byte_in = b; bus_a.byte_valid_in = v; end
        else        begin bus_b.byte_in = b; bus_b.byte_valid_in = v; end
    endtask

    task automatic set_ctl(logic s, logic f);
        bus_a.start_in = s; bus_a.finish_in = f;
        bus_b.start_in = s; bus_b.finish_in = f;
    endtask

    task automatic do_start();
        set_ctl(1'b1, 1'b0);
        tick();
        set_ctl(1'b0, 1'b0);
        model_clear(1'b1);
    endtask

    // Offers the first n bytes of rec to every still-receiving instance.
    task automatic send_bytes(logic [47:0] rec, int n, bit gaps);
        for (int i = 0; i < n; i++) begin
            logic [7:0] b;
            bit         pend[2];
            bit         acc[2];
            int         budget;
            b = rec[47-8*i -: 8];
            budget = 40;
            if (gaps) repeat ($urandom_range(0, 3)) tick();
            for (int k = 0; k < 2; k++) begin
                pend[k] = m_live[k];
                if (pend[k]) set_byte(k, b, 1'b1);
            end
            while ((pend[0] || pend[1]) && budget > 0) begin
                @(negedge clk);
                for (int k = 0; k < 2; k++) acc[k] = pend[k] && obs(k).rdy;
                tick();
                for (int k = 0; k < 2; k++) begin
                    if (acc[k]) begin
                        pend[k] = 1'b0;
                        set_byte(k, 8'h00, 1'b0);
                        m_idx[k]++;
                    end
                end
                budget--;
            end
            for (int k = 0; k < 2; k++) begin
                if (pend[k]) begin
                    check($sformatf("byte_timeout_d%0d", k), 1, 0);
                    set_byte(k, 8'h00, 1'b0);
                end
            end
        end
    endtask

    task automatic send_record(logic [47:0] rec, bit gaps);
        send_bytes(rec, 6, gaps);
        for (int k = 0; k < 2; k++) if (m_live[k]) model_record(k, rec);
    endtask

    task automatic do_finish(bit with_valid);
        tick();
        set_ctl(1'b0, 1'b1);
        if (with_valid) begin
            set_byte(0, 8'hA5, 1'b1);
            set_byte(1, 8'hA5, 1'b1);
            @(negedge clk);
            for (int k = 0; k < 2; k++)
                check($sformatf("ready_during_finish_d%0d", k), obs(k).rdy, 0);
        end
        tick();
        set_ctl(1'b0, 1'b0);
        set_byte(0, 8'h00, 1'b0);
        set_byte(1, 8'h00, 1'b0);
        for (int k = 0; k < 2; k++) begin
            if (m_live[k]) begin
                if (m_idx[k] == 0) begin
                    push_exp(k, 0, 48'(m_cnt[k]));
                    m_done[k] = 1'b1;
                end else begin
                    m_err[k] = 3;
                end
                m_live[k] = 1'b0;
            end
        end
    endtask

    task automatic check_end();
        int budget;
        budget = 20;
        do begin
            @(negedge clk);
            budget--;
        end while ((obs(0).busy || obs(1).busy) && budget > 0);
        tick();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            obs_t o;
            o = obs(k);
            check($sformatf("busy_d%0d", k),  o.busy, 0);
            check($sformatf("error_d%0d", k), o.err,  m_err[k]);
            check($sformatf("done_d%0d", k),  o.done, m_done[k]);
            check($sformatf("count_d%0d", k), o.cnt,  m_cnt[k]);
            check($sformatf("pending_writes_d%0d", k), qsize(k), 0);
            while (qsize(k) > 0) void'(qpop(k));
        end
    endtask

    task automatic check_zero();
        for (int k = 0; k < 2; k++) begin
            obs_t o;
            o = obs(k);
            check($sformatf("zero_all_d%0d", k), 64'(o), 0);
            check($sformatf("zero_count_d%0d", k), o.cnt, 0);
        end
    endtask

    // Every cycle: each write must be the next predicted one; invariants hold.
    always @(negedge clk) begin
        obs_t o;
        wr_t  w;
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                o = obs(k);
                if (o.we) begin
                    if (qsize(k) == 0) begin
                        check($sformatf("unexpected_write_d%0d_addr%0d", k, o.addr), 1, 0);
                    end else begin
                        w = qpop(k);
                        check($sformatf("write_addr_d%0d", k), o.addr, w.addr);
                        check($sformatf("write_din_d%0d", k),  o.din,  w.din);
                    end
                    ram[k][o.addr] = o.din;
                end
                check($sformatf("ready_implies_busy_d%0d", k), o.rdy & ~o.busy, 0);
                check($sformatf("done_err_exclusive_d%0d", k), o.done && (o.err != 2'd0), 0);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [47:0] lit;
        set_ctl(1'b0, 1'b0);
        set_byte(0, 8'h00, 1'b0);
        set_byte(1, 8'h00, 1'b0);
        model_clear(1'b0);
        for (int k = 0; k < 2; k++)
            for (int a = 0; a < 257; a++) ram[k][a] = '0;
        repeat (2) tick();
        @(negedge clk);
        check_zero();
        tick();
        rst = 1'b0;

        cur_test = "t1_single";
        do_start();
        lit = 48'h048D1580064A;
        send_record(lit, 1'b0);
        do_finish(1'b0);
        check_end();
        check("lit_ram1", ram[0][1], 48'h048D1580064A);
        check("lit_ram0", ram[0][0], 48'd1);
        check("lit_done", bus_a.done_out, 1);
        check("lit_count", bus_a.record_count_out, 1);

        cur_test = "t2_time_order";
        do_start();
        send_record(mk(1, 2, 100, 1, 0) | 48'hC000_0000_0000, 1'b0);
        send_record(mk(3, 4, 100, 0, 4), 1'b0);
        send_record(mk(5, 6, 50, 0, 1), 1'b0);
        do_finish(1'b0);
        check_end();
        check("lit_ram1_top_bits", ram[0][1], 48'h000400800648);
        check("lit_ram2", ram[0][2], 48'h000C01000644);
        check("lit_err2", bus_a.error_out, 2);
        check("lit_count2", bus_a.record_count_out, 2);

        cur_test = "t3_bad_dir";
        do_start();
        send_record(mk(7, 7, 10, 0, 5), 1'b0);
        do_finish(1'b0);
        check_end();
        check("lit_err1", bus_a.error_out, 1);
        check("lit_busy0", bus_a.busy_out, 0);

        cur_test = "t4_overflow";
        do_start();
        for (int i = 1; i <= 5; i++) send_record(mk(i, 2 * i, 10 * i, i % 2, 1), 1'b0);
        do_finish(1'b0);
        check_end();
        check("lit_b_err3", bus_b.error_out, 3);
        check("lit_b_count4", bus_b.record_count_out, 4);
        check("lit_a_count5", bus_a.record_count_out, 5);
        check("lit_b_ram4", ram[1][4], mk(4, 8, 40, 0, 1));

        cur_test = "t5_truncated";
        do_start();
        send_bytes(mk(9, 9, 9, 1, 3), 3, 1'b0);
        do_finish(1'b0);
        check_end();
        check("lit_trunc_err3", bus_a.error_out, 3);

        cur_test = "t5_finish_with_valid";
        do_start();
        send_record(mk(11, 12, 13, 1, 2), 1'b0);
        do_finish(1'b1);
        check_end();
        check("lit_fv_count1", bus_a.record_count_out, 1);

        cur_test = "t6_reset_abort";
        do_start();
        send_bytes(mk(1, 1, 1, 0, 0), 4, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_clear(1'b0);
        @(negedge clk);
        check_zero();
        tick();
        do_start();
        send_record(mk(20, 21, 22, 1, 4), 1'b0);
        do_finish(1'b0);
        check_end();
        check("lit_rst_ram1", ram[0][1], mk(20, 21, 22, 1, 4));
        check("lit_rst_count1", bus_a.record_count_out, 1);

        cur_test = "t7_gaps";
        do_start();
        send_record(mk(100, 200, 1000, 0, 0), 1'b1);
        send_record(mk(300, 400, 1000, 1, 3), 1'b1);
        send_record(mk(500, 600, 2000, 0, 2), 1'b1);
        do_finish(1'b0);
        check_end();
        check("lit_gap_ram3", ram[0][3], mk(500, 600, 2000, 0, 2));
        check("lit_gap_ram0", ram[0][0], 48'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
